// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state encodings and transfer-length codes for the byte-wide memory controller.
package mem_ctrl_pkg;

    localparam int unsigned RAM_AW = 17;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TAG_W  = WORD_W - 2;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // Byte count of a transfer; the reserved code 11 behaves as a word.
    function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return CNT_W'(1);
            LEN_H:   return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, data and RAM-port signals of the memory controller; slave = controller view.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                if_req_i;
    logic [WORD_W-1:0]   if_addr_i;
    logic [WORD_W-1:0]   if_data_o;
    logic                if_done_o;
    logic                mem_req_i;
    logic                mem_we_i;
    logic [1:0]          mem_len_i;
    logic [WORD_W-1:0]   mem_addr_i;
    logic [WORD_W-1:0]   mem_wdata_i;
    logic [WORD_W-1:0]   mem_rdata_o;
    logic                mem_done_o;
    logic [RAM_AW-1:0]   ram_addr_o;
    logic [BYTE_W-1:0]   ram_dout_o;
    logic                ram_wr_o;
    logic [BYTE_W-1:0]   ram_din_i;
    logic                if_stall_req_o;
    logic                mem_stall_req_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
        output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_addr_o, ram_dout_o, ram_wr_o,
               if_stall_req_o, mem_stall_req_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
        input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_addr_o, ram_dout_o, ram_wr_o,
               if_stall_req_o, mem_stall_req_o
    );

endinterface

// File: rtl/mem_ctrl_fetch_buf.sv
// One-entry instruction fetch buffer: tag compare, fill on RAM fetch, invalidate on overlapping store.
module mem_ctrl_fetch_buf
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic [TAG_W-1:0]   look_tag,
    output logic               hit_c,
    output logic [WORD_W-1:0]  data,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [WORD_W-1:0]  fill_data,
    input  logic               inval_en,
    input  logic [WORD_W-1:0]  inval_addr,
    input  logic [CNT_W-1:0]   inval_len
);
    logic               vld_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WORD_W-1:0]  data_q;
    logic [TAG_W-1:0]   st_tag_c;
    logic               cross_c;
    logic               overlap_c;

    // A store of up to 4 bytes touches at most its own word and the next one.
    assign st_tag_c  = inval_addr[WORD_W-1:2];
    assign cross_c   = (CNT_W'(inval_addr[1:0]) + inval_len) > CNT_W'(4);
    assign overlap_c = (st_tag_c == tag_q) || (cross_c && ((st_tag_c + TAG_W'(1)) == tag_q));

    assign hit_c = vld_q && (tag_q == look_tag);
    assign data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (rdy) begin
            if (fill_en) begin
                vld_q  <= 1'b1;
                tag_q  <= fill_tag;
                data_q <= fill_data;
            end else if (inval_en && overlap_c) begin
                vld_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller: arbitrates fetch and data requests onto one 8-bit synchronous RAM port.
// Define MEM_CTRL_FETCH_BUF_EN to add a one-entry fetch buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);
    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [RAM_AW-1:0]  base_q, base_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [RAM_AW-1:0]  addr_q, addr_d;
    logic [BYTE_W-1:0]  dout_q, dout_d;
    logic               wr_q, wr_d;
    logic [WORD_W-1:0]  if_data_q, if_data_d;
    logic [WORD_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic               if_done_q, if_done_d;
    logic               mem_done_q, mem_done_d;
    logic [BYTE_W-1:0]  hold_q;
    logic               hold_vld_q;

    logic [BYTE_W-1:0]  din_c;
    logic [RAM_AW-1:0]  next_addr_c;
    logic [1:0]         cap_idx_c;
    logic [WORD_W-1:0]  rd_asm_c;
    logic               buf_hit_c;
    logic [WORD_W-1:0]  buf_data;
    logic               if_done_c;
    logic               mem_done_c;

`ifdef MEM_CTRL_FETCH_BUF_EN
    logic               fill_c;
    logic               inval_c;

    mem_ctrl_fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .look_tag   (bus.if_addr_i[WORD_W-1:2]),
        .hit_c      (buf_hit_c),
        .data       (buf_data),
        .fill_en    (fill_c),
        .fill_tag   (bus.if_addr_i[WORD_W-1:2]),
        .fill_data  (rd_asm_c),
        .inval_en   (inval_c),
        .inval_addr (bus.mem_addr_i),
        .inval_len  (len_bytes(bus.mem_len_i))
    );
`else
    assign buf_hit_c = 1'b0;
    assign buf_data  = '0;
`endif

    // RAM byte currently due for capture; the held copy covers a rdy freeze.
    assign din_c       = hold_vld_q ? hold_q : bus.ram_din_i;
    assign next_addr_c = base_q + RAM_AW'(cnt_q);
    assign cap_idx_c   = 2'(cnt_q - CNT_W'(2));

    always_comb begin
        rd_asm_c = asm_q;
        rd_asm_c[{cap_idx_c, 3'b000} +: BYTE_W] = din_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        asm_d       = asm_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_d        = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_CTRL_FETCH_BUF_EN
        fill_c      = 1'b0;
        inval_c     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // The done cycle is skipped so a still-held request is re-accepted one cycle later.
                if (!if_done_q && !mem_done_q) begin
                    if (bus.mem_req_i) begin
                        owner_d = OWN_MEM;
                        len_d   = len_bytes(bus.mem_len_i);
                        base_d  = RAM_AW'(bus.mem_addr_i);
                        addr_d  = RAM_AW'(bus.mem_addr_i);
                        cnt_d   = CNT_W'(1);
                        if (bus.mem_we_i) begin
                            state_d = ST_WR;
                            asm_d   = bus.mem_wdata_i;
                            dout_d  = bus.mem_wdata_i[BYTE_W-1:0];
                            wr_d    = 1'b1;
`ifdef MEM_CTRL_FETCH_BUF_EN
                            inval_c = 1'b1;
`endif
                        end else begin
                            state_d = ST_RD;
                            asm_d   = '0;
                        end
                    end else if (bus.if_req_i) begin
                        if (buf_hit_c) begin
                            if_done_d = 1'b1;
                            if_data_d = buf_data;
                        end else begin
                            state_d = ST_RD;
                            owner_d = OWN_IF;
                            len_d   = CNT_W'(4);
                            base_d  = RAM_AW'(bus.if_addr_i);
                            addr_d  = RAM_AW'(bus.if_addr_i);
                            cnt_d   = CNT_W'(1);
                            asm_d   = '0;
                        end
                    end
                end
            end
            ST_RD: begin
                // cnt is the current cycle of the read: address k+1 goes out, byte cnt-2 comes in.
                if (cnt_q >= CNT_W'(2)) asm_d = rd_asm_c;
                if (cnt_q < len_q) addr_d = next_addr_c;
                if (cnt_q == (len_q + CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (owner_q == OWN_IF) begin
                        if_done_d = 1'b1;
                        if_data_d = rd_asm_c;
`ifdef MEM_CTRL_FETCH_BUF_EN
                        fill_c    = 1'b1;
`endif
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = rd_asm_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR: begin
                if (cnt_q < len_q) begin
                    addr_d = next_addr_c;
                    dout_d = asm_q[{cnt_q[1:0], 3'b000} +: BYTE_W];
                    wr_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            asm_q       <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            wr_q        <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            asm_q       <= asm_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            hold_vld_q  <= 1'b0;
        end else if (!hold_vld_q) begin
            // The RAM keeps reading the frozen address, so keep the byte that was due.
            hold_q     <= bus.ram_din_i;
            hold_vld_q <= 1'b1;
        end
    end

    assign if_done_c  = if_done_q & rdy;
    assign mem_done_c = mem_done_q & rdy;

    assign bus.ram_addr_o      = addr_q;
    assign bus.ram_dout_o      = dout_q;
    assign bus.ram_wr_o        = wr_q & rdy;
    assign bus.if_data_o       = if_data_q;
    assign bus.if_done_o       = if_done_c;
    assign bus.mem_rdata_o     = mem_rdata_q;
    assign bus.mem_done_o      = mem_done_c;
    assign bus.if_stall_req_o  = bus.if_req_i & ~if_done_c;
    assign bus.mem_stall_req_o = bus.mem_req_i & ~mem_done_c;

endmodule
